bc4_seq_checker: RTL and testbench
==================================

Name: bc4_seq_checker

Overview:
Receive-side monitor for the 4-bit binary up-counter (bC4) output bus. It samples the count stream and locks onto the +1 mod 16 sequence. Once locked it flags every discontinuity, counts errors and wrap-arounds, and reports lock status. It sits downstream of bC4, or of any free-running count source, as a self-check and debug block.

Parameters:
WIDTH, 4, width of the monitored count bus; sequence is +1 mod 2^WIDTH.
LOCK_LEN, 3, consecutive correct increments required to declare lock (1..15).
CNT_W, 8, width of the err_count and wrap_count counters.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
q_in  input  WIDTH  count value under test.
q_valid  input  1  q_in is sampled only on cycles where this is 1.
clr_err  input  1  synchronous clear of err_count.
locked  output  1  1 while in LOCKED state.
err_pulse  output  1  one-cycle pulse per sequence error detected while locked.
wrap_pulse  output  1  one-cycle pulse when a locked stream wraps from all-ones to 0.
expected  output  WIDTH  next value the checker expects.
err_count  output  CNT_W  saturating error counter.
wrap_count  output  CNT_W  wrap counter; rolls over modulo 2^CNT_W.

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately):
  - state=IDLE, match_cnt=0.
  - locked, err_pulse, wrap_pulse, expected, err_count and wrap_count all 0.
  - Reset mid-stream discards lock; reacquisition starts from IDLE.
- All outputs are registered. Response appears the cycle after the sampled edge (latency 1).
- q_valid=0: state, expected, match_cnt and the counters hold; err_pulse and wrap_pulse are 0.
- FSM states: IDLE, ACQ, LOCKED. The following rules apply on valid samples.
- IDLE:
  - expected<=q_in+1 (mod 2^WIDTH), match_cnt<=0, go to ACQ.
  - No error is reported.
- ACQ, when q_in==expected:
  - match_cnt++ and expected<=q_in+1.
  - If match_cnt+1==LOCK_LEN: go to LOCKED and set locked<=1.
- ACQ, when q_in!=expected:
  - match_cnt<=0 and expected<=q_in+1 (resync); stay in ACQ.
  - No err_pulse and no err_count change.
- LOCKED, when q_in==expected:
  - expected<=q_in+1.
  - If q_in==0 (i.e. the prior value was all-ones): wrap_pulse<=1 and wrap_count++ (modulo).
- LOCKED, when q_in!=expected:
  - err_pulse<=1 and err_count++, saturating at 2^CNT_W-1.
  - locked<=0, go to ACQ, match_cnt<=0, expected<=q_in+1.
- Repeated value (stall) while locked is an error. A skip is also an error. No tolerance window.
- clr_err=1: err_count<=0, independent of q_valid.
  - clr_err coincident with a new error: err_count<=1 (the error is counted after the clear).
  - clr_err does not affect state, locked or err_pulse.
- LOCK_LEN counts matches after the first (seed) sample. Lock is asserted the cycle after sample LOCK_LEN+1 of a clean run.
- expected is visible in every state. In IDLE it reads 0.

Test Plan:
- Lock acquisition: reset released, q_valid=1, q_in=5,6,7,8 on consecutive edges -> locked=0 through sample 7; locked=1 the cycle after 8; expected=9; err_count=0.
- Wrap: locked stream ...,14,15,0,1 -> wrap_pulse=1 for exactly one cycle after sample 0; wrap_count 0->1; no err_pulse.
- Error and relock: locked at 3, q_in=4,9,10,11,12 -> err_pulse one cycle after 9; err_count=1; locked=0; locked returns to 1 after sample 12.
- Gaps and noise in ACQ: locked stream 2,3 then q_valid=0 for 4 cycles, then 4 -> no error, outputs held. Separately, from reset feed 1,2,7,8,9,10 -> no err_pulse; locked=1 after 10.
- Saturation and clear: force CNT_W=2 build, inject 5 errors -> err_count sticks at 3. Assert clr_err on the same edge as a 6th error -> err_count=1.
- Async reset mid-lock: assert reset=0 between edges while locked with wrap_count=2 -> all outputs 0 immediately, without waiting for a clock edge. After release, first sample does not produce err_pulse.

Source files
------------

// File: rtl/bc4_seq_checker.sv
// Receive-side monitor for a +1 mod 2^WIDTH count stream.
// Locks after LOCK_LEN clean increments, then flags breaks and counts wraps.
module bc4_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    localparam logic [3:0]       LOCK_N  = 4'(LOCK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [3:0]       match_cnt;
    logic [WIDTH-1:0] nxt;
    logic             hit;

    assign nxt = q_in + 1'b1;
    assign hit = (q_in == expected);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            match_cnt  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            expected   <= '0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (clr_err) begin
                err_count <= '0;
            end
            if (q_valid) begin
                unique case (state)
                    IDLE: begin
                        expected  <= nxt;
                        match_cnt <= '0;
                        state     <= ACQ;
                    end
                    ACQ: begin
                        expected <= nxt;
                        if (hit) begin
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        expected <= nxt;
                        if (hit) begin
                            if (q_in == '0) begin
                                wrap_pulse <= 1'b1;
                                wrap_count <= wrap_count + 1'b1;
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            // a clear on the same edge still keeps this error
                            if (clr_err) begin
                                err_count <= CNT_W'(1);
                            end else if (err_count != CNT_MAX) begin
                                err_count <= err_count + 1'b1;
                            end
                            locked    <= 1'b0;
                            state     <= ACQ;
                            match_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bc4_seq_checker.sv
// Directed bench for bc4_seq_checker: lock, wrap, error/relock, gaps,
// async reset, and counter saturation/clear on a narrow-counter build.
module tb_bc4_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] q_in;
    logic       q_valid;
    logic       clr_err;
    logic       locked, err_pulse, wrap_pulse;
    logic [3:0] expected;
    logic [7:0] err_count, wrap_count;

    logic [3:0] b_q;
    logic       b_valid;
    logic       b_clr;
    logic       b_locked, b_err_pulse, b_wrap_pulse;
    logic [3:0] b_expected;
    logic [1:0] b_err_count, b_wrap_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bc4_seq_checker dut (
        .clk        (clk),
        .reset      (rst_n),
        .q_in       (q_in),
        .q_valid    (q_valid),
        .clr_err    (clr_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .expected   (expected),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    bc4_seq_checker #(.WIDTH(4), .LOCK_LEN(3), .CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (rst_n),
        .q_in       (b_q),
        .q_valid    (b_valid),
        .clr_err    (b_clr),
        .locked     (b_locked),
        .err_pulse  (b_err_pulse),
        .wrap_pulse (b_wrap_pulse),
        .expected   (b_expected),
        .err_count  (b_err_count),
        .wrap_count (b_wrap_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [3:0] v);
        @(negedge clk);
        q_in    = v;
        q_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic b_sample(input logic [3:0] v, input logic c);
        @(negedge clk);
        b_q     = v;
        b_valid = 1'b1;
        b_clr   = c;
        @(posedge clk);
        #1;
        b_clr   = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        q_in    = '0;
        q_valid = 1'b0;
        clr_err = 1'b0;
        b_q     = '0;
        b_valid = 1'b0;
        b_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_expected", expected, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_wrap_count", wrap_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // lock acquisition on 5,6,7,8
        sample(4'd5);
        chk("acq5_locked", locked, 0);
        chk("acq5_expected", expected, 6);
        sample(4'd6);
        chk("acq6_locked", locked, 0);
        sample(4'd7);
        chk("acq7_locked", locked, 0);
        sample(4'd8);
        chk("acq8_locked", locked, 1);
        chk("acq8_expected", expected, 9);
        chk("acq8_err_count", err_count, 0);

        // run up to the wrap
        for (int v = 9; v <= 15; v++) sample(4'(v));
        chk("pre_wrap_expected", expected, 0);
        chk("pre_wrap_pulse", wrap_pulse, 0);
        sample(4'd0);
        chk("wrap_pulse", wrap_pulse, 1);
        chk("wrap_count1", wrap_count, 1);
        chk("wrap_no_err", err_pulse, 0);
        sample(4'd1);
        chk("wrap_pulse_once", wrap_pulse, 0);
        chk("wrap_count_hold", wrap_count, 1);

        // gap of 4 invalid cycles while locked
        sample(4'd2);
        sample(4'd3);
        @(negedge clk);
        q_valid = 1'b0;
        q_in    = 4'd12;
        repeat (4) @(posedge clk);
        #1;
        chk("gap_expected", expected, 4);
        chk("gap_locked", locked, 1);
        chk("gap_err", err_pulse, 0);
        sample(4'd4);
        chk("gap_resume_err", err_pulse, 0);
        chk("gap_resume_expected", expected, 5);

        // skip error and relock
        sample(4'd5);
        sample(4'd9);
        chk("skip_err_pulse", err_pulse, 1);
        chk("skip_err_count", err_count, 1);
        chk("skip_locked", locked, 0);
        chk("skip_expected", expected, 10);
        sample(4'd10);
        chk("relock10_pulse", err_pulse, 0);
        chk("relock10_locked", locked, 0);
        sample(4'd11);
        chk("relock11_locked", locked, 0);
        sample(4'd12);
        chk("relock12_locked", locked, 1);
        chk("relock12_err_count", err_count, 1);

        // clear with q_valid low
        @(negedge clk);
        q_valid = 1'b0;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_err_count", err_count, 0);
        chk("clr_locked", locked, 1);

        // second wrap, then async reset mid-lock
        for (int v = 13; v <= 15; v++) sample(4'(v));
        sample(4'd0);
        chk("wrap_count2", wrap_count, 2);
        @(negedge clk);
        q_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_err_pulse", err_pulse, 0);
        chk("arst_wrap_pulse", wrap_pulse, 0);
        chk("arst_expected", expected, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_wrap_count", wrap_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // noise during acquisition: 1,2,7,8,9,10
        sample(4'd1);
        chk("noise1_err", err_pulse, 0);
        chk("noise1_expected", expected, 2);
        sample(4'd2);
        sample(4'd7);
        chk("noise7_err", err_pulse, 0);
        chk("noise7_expected", expected, 8);
        sample(4'd8);
        sample(4'd9);
        chk("noise9_locked", locked, 0);
        sample(4'd10);
        chk("noise10_locked", locked, 1);
        chk("noise10_err_count", err_count, 0);
        @(negedge clk);
        q_valid = 1'b0;

        // narrow counter: lock, then 5 errors each followed by relock
        b_sample(4'd0, 1'b0);
        b_sample(4'd1, 1'b0);
        b_sample(4'd2, 1'b0);
        b_sample(4'd3, 1'b0);
        chk("sat_locked", b_locked, 1);
        begin
            logic [3:0] v;
            v = 4'd3;
            for (int k = 1; k <= 5; k++) begin
                v = v + 4'd5;
                b_sample(v, 1'b0);
                chk("sat_err_pulse", b_err_pulse, 1);
                chk("sat_err_count", b_err_count, (k > 3) ? 3 : k);
                for (int j = 1; j <= 3; j++) begin
                    v = v + 4'd1;
                    b_sample(v, 1'b0);
                end
                chk("sat_relocked", b_locked, 1);
            end
            v = v + 4'd5;
            b_sample(v, 1'b1);
            chk("sat_clr_err_pulse", b_err_pulse, 1);
            chk("sat_clr_err_count", b_err_count, 1);
            chk("sat_clr_locked", b_locked, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
